// File: rtl/data_cache.sv
// Direct-mapped write-back, write-allocate data cache in front of data_memory.
// Ports: CPU word side (read/write/address/writedata/readdata/busywait), memory block side (mem_*).
module data_cache #(
    parameter int LINES = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         read,
    input  logic         write,
    input  logic [31:0]  address,
    input  logic [31:0]  writedata,
    output logic [31:0]  readdata,
    output logic         busywait,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_address,
    output logic [127:0] mem_writedata,
    input  logic [127:0] mem_readdata,
    input  logic         mem_busywait
);

    localparam int IDX  = $clog2(LINES);
    localparam int TAGW = 28 - IDX;

    typedef enum logic [1:0] {
        IDLE,
        WRITE_BACK,
        MEM_READ,
        UPDATE
    } state_t;

    state_t state;

    logic [LINES-1:0] valid;
    logic [LINES-1:0] dirty;
    logic [TAGW-1:0]  tags [LINES];
    logic [127:0]     data [LINES];
    logic [127:0]     fill;
    logic             issued;

    logic [IDX-1:0]  idx;
    logic [TAGW-1:0] tag;
    logic [1:0]      word;
    logic [6:0]      wofs;
    logic            req;
    logic            hit;
    logic            done;
    logic            unused_addr;

    assign idx  = address[3+IDX:4];
    assign tag  = address[31:4+IDX];
    assign word = address[3:2];
    assign wofs = {word, 5'b0};
    assign req  = read | write;
    assign hit  = valid[idx] && (tags[idx] == tag);

    // A memory state may only finish once the request has been visible for
    // a full cycle, so a memory that raises busywait late is not mistaken
    // for an instant completion.
    assign done = issued && !mem_busywait;

    assign busywait = req && !(state == IDLE && hit);
    assign readdata = (state == IDLE && hit) ? data[idx][wofs +: 32] : '0;

    assign unused_addr = ^address[1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            valid         <= '0;
            dirty         <= '0;
            issued        <= 1'b0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        if (hit) begin
                            if (write) begin
                                data[idx][wofs +: 32] <= writedata;
                                dirty[idx]            <= 1'b1;
                            end
                        end else if (valid[idx] && dirty[idx]) begin
                            state         <= WRITE_BACK;
                            mem_write     <= 1'b1;
                            mem_address   <= {tags[idx], idx};
                            mem_writedata <= data[idx];
                        end else begin
                            state       <= MEM_READ;
                            mem_read    <= 1'b1;
                            mem_address <= address[31:4];
                        end
                    end
                end
                WRITE_BACK: begin
                    issued <= 1'b1;
                    if (done) begin
                        issued      <= 1'b0;
                        dirty[idx]  <= 1'b0;
                        mem_write   <= 1'b0;
                        mem_read    <= 1'b1;
                        mem_address <= address[31:4];
                        state       <= MEM_READ;
                    end
                end
                MEM_READ: begin
                    issued <= 1'b1;
                    if (done) begin
                        issued   <= 1'b0;
                        mem_read <= 1'b0;
                        fill     <= mem_readdata;
                        state    <= UPDATE;
                    end
                end
                UPDATE: begin
                    data[idx]  <= fill;
                    tags[idx]  <= tag;
                    valid[idx] <= 1'b1;
                    dirty[idx] <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-back, write-allocate data cache between the CPU load/store stage and the block-level `data_memory`. It serves 32-bit word accesses from the CPU. On a miss it writes back a dirty victim block and fetches a 128-bit block through the memory's read/write/busywait handshake. The memory-side ports connect one-to-one to `data_memory` (28-bit block address, 128-bit data).

## Interface
- `LINES`, 8: number of cache lines (power of two). Index width is IDX = log2(LINES). Tag width is 28−IDX.
- `clock` input 1: single clock; all state updates on posedge.
- `reset` input 1: synchronous, active-high.
- `read` input 1: CPU word read request; held until `busywait` is low.
- `write` input 1: CPU word write request; held until `busywait` is low.
- `address` input 32: CPU byte address. Bits [1:0] are ignored, [3:2] select the word, [3+IDX:4] select the index, [31:4+IDX] form the tag.
- `writedata` input 32: CPU write word.
- `readdata` output 32: selected word on a read hit.
- `busywait` output 1: CPU stall.
- `mem_read` output 1: block read request to memory.
- `mem_write` output 1: block write request to memory.
- `mem_address` output 28: block address.
- `mem_writedata` output 128: victim block.
- `mem_readdata` input 128: fetched block.
- `mem_busywait` input 1: memory busy.

## Operation
- Per line: valid bit, dirty bit, tag, and a 128-bit block. Word w occupies bits [32w+31:32w].
- hit = valid[idx] && (tag[idx] == address tag).
- FSM states: IDLE, WRITE_BACK, MEM_READ, UPDATE.
- **IDLE**, no request: no action.
- **IDLE**, request and hit:
  - Read: `readdata` is driven combinationally from the line.
  - Write: at posedge, the word is stored and dirty is set to 1.
  - State stays IDLE.
- **IDLE**, request and miss: go to WRITE_BACK if valid && dirty, otherwise go to MEM_READ.
- **WRITE_BACK**:
  - `mem_write`=1, `mem_address`={stored tag, idx}, `mem_writedata`=line block.
  - Go to MEM_READ at completion, then clear dirty.
- **MEM_READ**:
  - `mem_read`=1, `mem_address`=address[31:4].
  - Go to UPDATE at completion.
- **UPDATE**:
  - At posedge, block ← `mem_readdata` (latched at completion), tag ← address tag, valid=1, dirty=0.
  - Go to IDLE. The access is then re-evaluated as a hit.
- Completion rule: an `issued` flag is set on the first cycle in WRITE_BACK or MEM_READ. Completion is the first posedge with `issued`=1 and `mem_busywait`=0. The flag clears on leaving the state. This tolerates memory raising busywait one cycle after the request.
- `read` and `write` both high: treated as a write.
- Address, data and request must stay stable while `busywait`=1. Behaviour is undefined otherwise.

## Timing
- Reset at posedge:
  - All valid and dirty bits cleared; state IDLE.
  - `mem_read`=`mem_write`=0, `mem_address`=0, `mem_writedata`=0.
  - `busywait`=0 while no request; `readdata`=0.
- Reset mid-miss: the FSM returns to IDLE and memory requests drop in the same cycle. The pending CPU access is abandoned.
- `busywait` = (read|write) && !(state==IDLE && hit). It is combinational.
- A hit completes in the request cycle with zero stall.
- Clean miss costs Lm + 2 stall cycles, where Lm is the memory busy period: the request cycle, MEM_READ, then UPDATE.
- Dirty miss adds Lm + 1 cycles for WRITE_BACK.
- `mem_read` and `mem_write` are never high in the same cycle.
- Each request is deasserted on the cycle following completion.
- Memory outputs are held constant for the whole state.

## Test plan
- **Reset:** after reset, read 0x00000010 → `busywait`=1; one `mem_read` with `mem_address`=0x0000001; no `mem_write`; word returned equals `data_memory` contents.
- **Read hit:** repeat the read of 0x00000010 → `busywait`=0 in the same cycle; `readdata` unchanged; no memory traffic.
- **Write hit then read:** write 0xDEADBEEF to 0x00000014 → zero stall. Read 0x00000014 → 0xDEADBEEF; the neighbouring word 0x10 is unchanged.
- **Conflict miss with dirty victim:** read 0x00000090 (same index 1, tag differs) → `mem_write` first with `mem_address`=0x0000001 and `mem_writedata` word 1 = 0xDEADBEEF, then `mem_read` with `mem_address`=0x0000009. Stall = 2Lm + 3.
- **Write miss, clean line:** write 0x12345678 to 0x00000028 → MEM_READ fill, then the write. Read back → 0x12345678; dirty set.
- **Reset mid-fill:** reset asserted during MEM_READ → `mem_read`=0 next cycle; state IDLE; a subsequent read of 0x00000010 misses again.
